// File: rtl/issue_rat_freelist_pkg.sv
// Shared issue-stage definitions for the rename free list: default widths
// and the free-list controller state encoding.
package issue_rat_freelist_pkg;

    localparam int unsigned PRF_WIDTH_DEF  = 6;
    localparam int unsigned FGR_WIDTH_DEF  = 3;
    localparam int unsigned ARCH_COUNT_DEF = 32;

    // INIT fills the free list with the PRFs not mapped at reset; RUN serves rename.
    typedef enum logic [0:0] {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_e;

endpackage

// File: rtl/issue_rat_freelist_fifo.sv
// Circular FIFO holding free physical register indices.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   i_wr_en/i_wr_prf - enqueue one PRF (dropped when full without a dequeue)
//   i_rd_en         - dequeue the head (ignored when empty)
//   o_head_c        - combinational view of the FIFO head
//   o_count         - registered number of stored entries (0..2^PRF_WIDTH)
module issue_rat_freelist_fifo #(
    parameter int unsigned PRF_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [PRF_WIDTH-1:0] i_wr_prf,
    input  logic                 i_rd_en,
    output logic [PRF_WIDTH-1:0] o_head_c,
    output logic [PRF_WIDTH:0]   o_count
);

    localparam int unsigned DEPTH = 1 << PRF_WIDTH;
    localparam int unsigned CNT_W = PRF_WIDTH + 1;

    logic [PRF_WIDTH-1:0] mem_q [DEPTH];
    logic [PRF_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PRF_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_c;
    logic                 empty_c;
    logic                 do_rd_c;
    logic                 do_wr_c;

    // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == '0);
        do_rd_c  = i_rd_en & ~empty_c;
        // A write into a full FIFO is only legal when an entry leaves the same cycle.
        do_wr_c  = i_wr_en & (~full_c | do_rd_c);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_rd_c) begin
            rd_ptr_d = rd_ptr_q + PRF_WIDTH'(1);
        end
        if (do_wr_c) begin
            wr_ptr_d = wr_ptr_q + PRF_WIDTH'(1);
        end
        case ({do_wr_c, do_rd_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; INIT defines every slot that is ever read.
    always_ff @(posedge clk) begin
        if (do_wr_c & ~reset) begin
            mem_q[wr_ptr_q] <= i_wr_prf;
        end
    end

    assign o_head_c = mem_q[rd_ptr_q];
    assign o_count  = count_q;

endmodule

// File: rtl/issue_rat_freelist.sv
// Rename free list: hands out free physical registers to rename, records each
// allocation into the FGR checkpoint, and takes PRFs back from retire
// (release) and from abandoned FGRs.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   i_alloc_valid/i_alloc_fgr     - rename requests one PRF for an FGR
//   o_alloc_ready/o_alloc_prf     - allocation fires / PRF handed out
//   o_acquired_*/i_acquired_ready - allocation record to the FGR checkpoint
//   i_abandoned_*/o_abandoned_ready - PRFs returned by an abandoned FGR
//   i_release_valid/i_release_prf - PRF freed at retire, never backpressured
//   o_count                       - registered free-entry count
//   o_init_done                   - free list initialised and serving
module issue_rat_freelist
    import issue_rat_freelist_pkg::*;
#(
    parameter int unsigned PRF_WIDTH  = PRF_WIDTH_DEF,
    parameter int unsigned FGR_WIDTH  = FGR_WIDTH_DEF,
    parameter int unsigned ARCH_COUNT = ARCH_COUNT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_alloc_valid,
    input  logic [FGR_WIDTH-1:0] i_alloc_fgr,
    output logic                 o_alloc_ready,
    output logic [PRF_WIDTH-1:0] o_alloc_prf,
    output logic                 o_acquired_valid,
    input  logic                 i_acquired_ready,
    output logic [FGR_WIDTH-1:0] o_acquired_fgr,
    output logic [PRF_WIDTH-1:0] o_acquired_prf,
    input  logic                 i_abandoned_valid,
    output logic                 o_abandoned_ready,
    input  logic [PRF_WIDTH-1:0] i_abandoned_prf,
    input  logic                 i_release_valid,
    input  logic [PRF_WIDTH-1:0] i_release_prf,
    output logic [PRF_WIDTH:0]   o_count,
    output logic                 o_init_done
);

    localparam int unsigned DEPTH  = 1 << PRF_WIDTH;
    localparam int unsigned INIT_N = DEPTH - ARCH_COUNT;
    localparam int unsigned ICNT_W = PRF_WIDTH + 1;

    fl_state_e            state_q, state_d;
    logic [ICNT_W-1:0]    init_cnt_q, init_cnt_d;
    logic                 run_c;
    logic                 wr_en_c;
    logic [PRF_WIDTH-1:0] wr_prf_c;
    logic [PRF_WIDTH-1:0] head_c;
    logic [PRF_WIDTH:0]   count_c;

    // Controller state and INIT fill counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FL_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state, write-port arbitration and handshake outputs.
    always_comb begin
        state_d           = state_q;
        init_cnt_d        = init_cnt_q;
        wr_en_c           = 1'b0;
        wr_prf_c          = '0;
        o_acquired_valid  = 1'b0;
        o_alloc_ready     = 1'b0;
        o_abandoned_ready = 1'b0;
        // Gated by reset so every handshake is quiet while reset is held.
        run_c             = (state_q == FL_RUN) & ~reset;

        case (state_q)
            FL_INIT: begin
                // Slot n receives PRF ARCH_COUNT+n; the FIFO write pointer tracks n.
                if (init_cnt_q < ICNT_W'(INIT_N)) begin
                    wr_en_c    = 1'b1;
                    wr_prf_c   = PRF_WIDTH'(ARCH_COUNT) + init_cnt_q[PRF_WIDTH-1:0];
                    init_cnt_d = init_cnt_q + ICNT_W'(1);
                end
                if (init_cnt_d == ICNT_W'(INIT_N)) begin
                    state_d = FL_RUN;
                end
            end
            FL_RUN: begin
                // Valid does not look at the checkpoint ready, avoiding a loop.
                o_acquired_valid  = run_c & i_alloc_valid & (count_c != '0);
                o_alloc_ready     = o_acquired_valid & i_acquired_ready;
                // Single write port: retire release always wins over abandon.
                o_abandoned_ready = run_c & ~i_release_valid;
                if (run_c & i_release_valid) begin
                    wr_en_c  = 1'b1;
                    wr_prf_c = i_release_prf;
                end else if (i_abandoned_valid & o_abandoned_ready) begin
                    wr_en_c  = 1'b1;
                    wr_prf_c = i_abandoned_prf;
                end
            end
            default: begin
                state_d = FL_INIT;
            end
        endcase
    end

    issue_rat_freelist_fifo #(
        .PRF_WIDTH (PRF_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (wr_en_c),
        .i_wr_prf (wr_prf_c),
        .i_rd_en  (o_alloc_ready),
        .o_head_c (head_c),
        .o_count  (count_c)
    );

    assign o_alloc_prf    = head_c;
    assign o_acquired_prf = head_c;
    assign o_acquired_fgr = i_alloc_fgr;
    assign o_count        = count_c;
    assign o_init_done    = (state_q == FL_RUN);

endmodule

// File: tb/tb_issue_rat_freelist.sv
// Scoreboard bench for issue_rat_freelist: a queue models the free list in
// order; returns push onto it, allocations pop and compare against the DUT.
module tb_issue_rat_freelist;

    localparam int unsigned PW = 6;
    localparam int unsigned FW = 3;

    logic          clk;
    logic          reset;
    logic          i_alloc_valid;
    logic [FW-1:0] i_alloc_fgr;
    logic          o_alloc_ready;
    logic [PW-1:0] o_alloc_prf;
    logic          o_acquired_valid;
    logic          i_acquired_ready;
    logic [FW-1:0] o_acquired_fgr;
    logic [PW-1:0] o_acquired_prf;
    logic          i_abandoned_valid;
    logic          o_abandoned_ready;
    logic [PW-1:0] i_abandoned_prf;
    logic          i_release_valid;
    logic [PW-1:0] i_release_prf;
    logic [PW:0]   o_count;
    logic          o_init_done;

    int unsigned   n_vec;
    int unsigned   n_err;
    logic [PW-1:0] fl_q [$];
    logic          run_m;

    issue_rat_freelist dut (
        .clk               (clk),
        .reset             (reset),
        .i_alloc_valid     (i_alloc_valid),
        .i_alloc_fgr       (i_alloc_fgr),
        .o_alloc_ready     (o_alloc_ready),
        .o_alloc_prf       (o_alloc_prf),
        .o_acquired_valid  (o_acquired_valid),
        .i_acquired_ready  (i_acquired_ready),
        .o_acquired_fgr    (o_acquired_fgr),
        .o_acquired_prf    (o_acquired_prf),
        .i_abandoned_valid (i_abandoned_valid),
        .o_abandoned_ready (o_abandoned_ready),
        .i_abandoned_prf   (i_abandoned_prf),
        .i_release_valid   (i_release_valid),
        .i_release_prf     (i_release_prf),
        .o_count           (o_count),
        .o_init_done       (o_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        i_alloc_valid     = 1'b0;
        i_alloc_fgr       = '0;
        i_acquired_ready  = 1'b0;
        i_release_valid   = 1'b0;
        i_release_prf     = '0;
        i_abandoned_valid = 1'b0;
        i_abandoned_prf   = '0;
    endtask

    // One RUN cycle: drive, check combinational handshakes at negedge,
    // update the model, then check the registered count after the edge.
    task automatic cyc(input logic av, input logic [FW-1:0] fgr, input logic ar,
                       input logic rv, input logic [PW-1:0] rp,
                       input logic bv, input logic [PW-1:0] bp);
        logic exp_acq;
        logic exp_fire;
        i_alloc_valid     = av;
        i_alloc_fgr       = fgr;
        i_acquired_ready  = ar;
        i_release_valid   = rv;
        i_release_prf     = rp;
        i_abandoned_valid = bv;
        i_abandoned_prf   = bp;
        @(negedge clk);
        exp_acq  = run_m && av && (fl_q.size() != 0);
        exp_fire = exp_acq && ar;
        chk("acq_valid", 32'(o_acquired_valid), 32'(exp_acq));
        chk("alloc_ready", 32'(o_alloc_ready), 32'(exp_fire));
        chk("aban_ready", 32'(o_abandoned_ready), 32'(run_m && !rv));
        if (fl_q.size() != 0) begin
            chk("alloc_prf", 32'(o_alloc_prf), 32'(fl_q[0]));
            if (exp_acq) begin
                chk("acq_prf", 32'(o_acquired_prf), 32'(fl_q[0]));
                chk("acq_fgr", 32'(o_acquired_fgr), 32'(fgr));
            end
        end
        if (exp_fire) void'(fl_q.pop_front());
        // A write into a full list without a same-cycle allocation is dropped.
        if (run_m && (rv || bv) && fl_q.size() < 64) begin
            fl_q.push_back(rv ? rp : bp);
        end
        @(posedge clk);
        #1;
        chk("count", 32'(o_count), 32'(fl_q.size()));
    endtask

    // Reset (with hostile inputs held), then walk the 32-cycle INIT.
    task automatic do_reset();
        reset             = 1'b1;
        i_alloc_valid     = 1'b1;
        i_acquired_ready  = 1'b1;
        i_release_valid   = 1'b1;
        i_release_prf     = PW'(5);
        i_abandoned_valid = 1'b1;
        i_abandoned_prf   = PW'(9);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_init_done", 32'(o_init_done), 32'd0);
        chk("rst_acq_valid", 32'(o_acquired_valid), 32'd0);
        chk("rst_alloc_ready", 32'(o_alloc_ready), 32'd0);
        chk("rst_aban_ready", 32'(o_abandoned_ready), 32'd0);
        reset = 1'b0;
        fl_q.delete();
        run_m = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("init_done_early", 32'(o_init_done), 32'd0);
            chk("init_acq_valid", 32'(o_acquired_valid), 32'd0);
            chk("init_alloc_ready", 32'(o_alloc_ready), 32'd0);
            chk("init_aban_ready", 32'(o_abandoned_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("init_done", 32'(o_init_done), 32'd1);
        chk("init_count", 32'(o_count), 32'd32);
        for (int i = 32; i < 64; i++) fl_q.push_back(PW'(i));
        run_m = 1'b1;
        drive_idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        run_m = 1'b0;
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        do_reset();

        // Head is PRF 32 after INIT.
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);

        // Drain all 32 initial PRFs in order, then one request on empty.
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, FW'(i), 1'b1, 1'b0, '0, 1'b0, '0);
        end
        cyc(1'b1, FW'(3), 1'b1, 1'b0, '0, 1'b0, '0);

        // No bypass: release into an empty list with a pending request.
        cyc(1'b1, FW'(1), 1'b1, 1'b1, PW'(5), 1'b0, '0);
        cyc(1'b1, FW'(2), 1'b1, 1'b0, '0, 1'b0, '0);

        // Release beats abandon; abandon lands next cycle; order 7 then 9.
        cyc(1'b0, '0, 1'b0, 1'b1, PW'(7), 1'b1, PW'(9));
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, PW'(9));
        cyc(1'b1, FW'(4), 1'b1, 1'b0, '0, 1'b0, '0);
        cyc(1'b1, FW'(5), 1'b1, 1'b0, '0, 1'b0, '0);

        // Fill to full across the pointer wrap, then one dropped write.
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, PW'(63 - i), 1'b0, '0);
        end
        cyc(1'b0, '0, 1'b0, 1'b1, PW'(17), 1'b0, '0);
        // Simultaneous allocate and release while full.
        cyc(1'b1, FW'(6), 1'b1, 1'b1, PW'(40), 1'b0, '0);

        // Checkpoint stalls three cycles; allocation fires on the fourth.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, FW'(7), 1'b0, 1'b0, '0, 1'b0, '0);
        end
        cyc(1'b1, FW'(7), 1'b1, 1'b0, '0, 1'b0, '0);

        // Mixed traffic with a reset in the middle.
        for (int c = 0; c < 100; c++) begin
            if (c == 50) begin
                do_reset();
            end else begin
                logic rv;
                rv = (fl_q.size() < 64) ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc(1'($urandom_range(0, 1)), FW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0), rv, PW'($urandom_range(0, 63)),
                    1'($urandom_range(0, 1)), PW'($urandom_range(0, 63)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
